// File: rtl/timed_start_scheduler.sv
// Multi-channel timed start trigger: each channel is armed with an absolute
// usec target and emits a fixed-width start pulse once the shared time base
// reaches it. Channels can re-arm periodically, be cancelled, and flag
// rejected deadlines or overlapping pulses in a sticky missed bit.
module timed_start_scheduler #(
    parameter int N_CH      = 4,
    parameter int TW        = 32,
    parameter int PULSE_LEN = 21,
    localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [TW-1:0]   usec,
    input  logic            wr_en,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [TW-1:0]   wr_time,
    input  logic [TW-1:0]   wr_period,
    input  logic            wr_mode,
    input  logic [N_CH-1:0] cancel,
    input  logic [N_CH-1:0] clear_missed,
    output logic [N_CH-1:0] start,
    output logic [N_CH-1:0] armed,
    output logic [N_CH-1:0] missed
);

    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state_q  [N_CH];
    state_t           state_d  [N_CH];
    logic [TW-1:0]    target_q [N_CH];
    logic [TW-1:0]    target_d [N_CH];
    logic [TW-1:0]    period_q [N_CH];
    logic [TW-1:0]    period_d [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    logic [TW-1:0]    d_hit    [N_CH];
    logic [N_CH-1:0]  mode_q, mode_d;
    logic [N_CH-1:0]  start_q, start_d;
    logic [N_CH-1:0]  missed_q, missed_d;
    logic [N_CH-1:0]  hit, wr_sel;
    logic [TW-1:0]    d_wr;
    logic             wr_ok;

    // A write is accepted only when its target is now or in the (wrapped) future.
    assign d_wr  = wr_time - usec;
    assign wr_ok = ~d_wr[TW-1];

    // Per-channel write select and wrap-aware "target reached" detection.
    always_comb begin
        hit    = '0;
        wr_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            d_hit[c]  = usec - target_q[c];
            hit[c]    = (state_q[c] == ARMED) && !d_hit[c][TW-1];
            wr_sel[c] = wr_en && (wr_ch == CHW'(c));
        end
    end

    // Next-state: write beats cancel beats hit; a new missed event beats clear.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_d[c]  = state_q[c];
            target_d[c] = target_q[c];
            period_d[c] = period_q[c];
            mode_d[c]   = mode_q[c];
            cnt_d[c]    = (cnt_q[c] != '0) ? cnt_q[c] - CNT_W'(1) : '0;
            missed_d[c] = missed_q[c] & ~clear_missed[c];

            if (wr_sel[c]) begin
                if (wr_ok) begin
                    target_d[c] = wr_time;
                    period_d[c] = wr_period;
                    mode_d[c]   = wr_mode;
                    state_d[c]  = ARMED;
                end else begin
                    state_d[c]  = IDLE;
                    missed_d[c] = 1'b1;
                end
            end else if (cancel[c]) begin
                // Disarm only; a pulse already running completes normally.
                state_d[c] = IDLE;
            end else if (hit[c]) begin
                if (mode_q[c] && (period_q[c] != '0)) begin
                    target_d[c] = target_q[c] + period_q[c];
                end else begin
                    state_d[c] = IDLE;
                end
                // Re-trigger during an active pulse extends it and flags overrun.
                if (cnt_q[c] != '0) begin
                    missed_d[c] = 1'b1;
                end
                cnt_d[c] = CNT_W'(PULSE_LEN);
            end

            start_d[c] = (cnt_d[c] != '0);
        end
    end

    // Channel state, timing and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c]  <= IDLE;
                target_q[c] <= '0;
                period_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            mode_q   <= '0;
            start_q  <= '0;
            missed_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c]  <= state_d[c];
                target_q[c] <= target_d[c];
                period_q[c] <= period_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            mode_q   <= mode_d;
            start_q  <= start_d;
            missed_q <= missed_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        armed = '0;
        for (int c = 0; c < N_CH; c++) begin
            armed[c] = (state_q[c] == ARMED);
        end
    end

    assign start  = start_q;
    assign missed = missed_q;

endmodule

// File: tb/tb_timed_start_scheduler.sv
// Directed bench for timed_start_scheduler with a queue-based scoreboard.
module tb_timed_start_scheduler;

    localparam int N_CH = 4;
    localparam int TW   = 32;
    localparam int PL   = 21;

    logic            clk = 1'b0;
    logic            rst;
    logic [TW-1:0]   usec;
    logic            wr_en;
    logic [1:0]      wr_ch;
    logic [TW-1:0]   wr_time;
    logic [TW-1:0]   wr_period;
    logic            wr_mode;
    logic [N_CH-1:0] cancel;
    logic [N_CH-1:0] clear_missed;
    logic [N_CH-1:0] start;
    logic [N_CH-1:0] armed;
    logic [N_CH-1:0] missed;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   lows;

    timed_start_scheduler #(.N_CH(N_CH), .TW(TW), .PULSE_LEN(PL)) dut (
        .clk          (clk),
        .rst          (rst),
        .usec         (usec),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_time      (wr_time),
        .wr_period    (wr_period),
        .wr_mode      (wr_mode),
        .cancel       (cancel),
        .clear_missed (clear_missed),
        .start        (start),
        .armed        (armed),
        .missed       (missed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] o);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h required none", o);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (o === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", e.tag, o, e.val);
        end
    endtask

    // Counts consecutive high cycles of start[ch], bounded.
    task automatic measure(input int ch, output int cnt);
        cnt = 0;
        while (start[ch] === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic do_write(input int ch, input logic [TW-1:0] t,
                            input logic [TW-1:0] p, input logic m);
        wr_en     = 1'b1;
        wr_ch     = 2'(ch);
        wr_time   = t;
        wr_period = p;
        wr_mode   = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; usec = '0; wr_en = 1'b0; wr_ch = '0; wr_time = '0;
        wr_period = '0; wr_mode = 1'b0; cancel = '0; clear_missed = '0;
        n = 0; lows = 0;

        // Reset state
        expect_val("rst_armed", 0);
        expect_val("rst_start", 0);
        expect_val("rst_missed", 0);
        tick(); tick();
        observe(32'(armed)); observe(32'(start)); observe(32'(missed));
        rst = 1'b0;

        // 1: one-shot
        usec = 100; do_write(0, 105, 0, 1'b0);
        expect_val("t1_armed", 1);
        tick(); wr_en = 1'b0;
        observe(32'(armed[0]));
        for (int u = 101; u <= 104; u++) begin
            usec = TW'(u);
            expect_val("t1_early", 0);
            tick();
            observe(32'(start[0]));
        end
        usec = 105;
        expect_val("t1_start", 1);
        expect_val("t1_disarm", 0);
        tick();
        observe(32'(start[0])); observe(32'(armed[0]));
        expect_val("t1_width", PL);
        measure(0, n); observe(n);

        // 2: periodic with cancel
        usec = 190; do_write(1, 200, 50, 1'b1);
        expect_val("t2_armed", 1);
        tick(); wr_en = 1'b0;
        observe(32'(armed[1]));
        usec = 200;
        expect_val("t2_start200", 1);
        expect_val("t2_rearmed", 1);
        tick();
        observe(32'(start[1])); observe(32'(armed[1]));
        expect_val("t2_width200", PL);
        measure(1, n); observe(n);
        usec = 250;
        expect_val("t2_start250", 1);
        tick();
        observe(32'(start[1]));
        usec = 260; cancel = 4'b0010;
        expect_val("t2_cancel_armed", 0);
        expect_val("t2_cancel_start", 1);
        tick(); cancel = '0;
        observe(32'(armed[1])); observe(32'(start[1]));
        expect_val("t2_width250_rest", PL - 1);
        measure(1, n); observe(n);
        usec = 300;
        expect_val("t2_no300", 0);
        expect_val("t2_missed", 0);
        tick(); tick();
        observe(32'(start[1])); observe(32'(missed[1]));

        // 3: past target rejected
        usec = 500; do_write(2, 499, 0, 1'b0);
        expect_val("t3_armed", 0);
        expect_val("t3_missed", 1);
        expect_val("t3_start", 0);
        tick(); wr_en = 1'b0;
        observe(32'(armed[2])); observe(32'(missed[2])); observe(32'(start[2]));
        clear_missed = 4'b0100;
        expect_val("t3_clear", 0);
        tick(); clear_missed = '0;
        observe(32'(missed[2]));

        // 4: wrap-around
        usec = 32'hFFFF_FFFE; do_write(3, 32'h0000_0002, 4, 1'b1);
        expect_val("t4_armed", 1);
        tick(); wr_en = 1'b0;
        observe(32'(armed[3]));
        usec = 32'hFFFF_FFFF; expect_val("t4_early_ff", 0); tick(); observe(32'(start[3]));
        usec = 32'h0;         expect_val("t4_early_0", 0);  tick(); observe(32'(start[3]));
        usec = 32'h1;         expect_val("t4_early_1", 0);  tick(); observe(32'(start[3]));
        usec = 32'h2;         expect_val("t4_fire2", 1);    tick(); observe(32'(start[3]));
        expect_val("t4_width", PL);
        measure(3, n); observe(n);
        usec = 5; expect_val("t4_early5", 0); tick(); observe(32'(start[3]));
        usec = 6; expect_val("t4_fire6", 1);  tick(); observe(32'(start[3]));
        cancel = 4'b1000; tick(); cancel = '0;
        measure(3, n);
        expect_val("t4_cancelled", 0);
        observe(32'(armed[3]));

        // 5: priority write > cancel > hit, then usec jump
        usec = 90; do_write(0, 95, 0, 1'b0);
        expect_val("t5_armed", 1);
        tick(); wr_en = 1'b0;
        observe(32'(armed[0]));
        usec = 95; do_write(0, 100, 0, 1'b0); cancel = 4'b0001;
        expect_val("t5_prio_armed", 1);
        expect_val("t5_prio_nopulse", 0);
        tick(); wr_en = 1'b0; cancel = '0;
        observe(32'(armed[0])); observe(32'(start[0]));
        usec = 90; expect_val("t5_before", 0); tick(); observe(32'(start[0]));
        usec = 120;
        expect_val("t5_jump_fire", 1);
        expect_val("t5_jump_disarm", 0);
        tick();
        observe(32'(start[0])); observe(32'(armed[0]));
        expect_val("t5_width", PL);
        measure(0, n); observe(n);

        // 6: overrun, then reset mid-pulse
        usec = 1000; do_write(1, 1001, 1, 1'b1);
        tick(); wr_en = 1'b0;
        lows = 0;
        for (int s = 0; s < 6; s++) begin
            usec = TW'(1001 + s);
            repeat (10) begin
                tick();
                if (start[1] !== 1'b1) lows++;
            end
        end
        expect_val("t6_continuous", 0);
        expect_val("t6_overrun", 1);
        observe(lows); observe(32'(missed[1]));
        rst = 1'b1;
        expect_val("t6_rst_start", 0);
        expect_val("t6_rst_armed", 0);
        expect_val("t6_rst_missed", 0);
        tick();
        observe(32'(start)); observe(32'(armed)); observe(32'(missed));
        rst = 1'b0;
        expect_val("t6_quiet", 0);
        tick(); tick();
        observe(32'(start));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
